window3x3_from_extended: RTL and testbench

- Consumes the extended raster stream produced by the row/column extender: WIDTH+1 pixels per line (one trailing dummy column), HEIGHT+1 lines (one trailing dummy line).
- Emits one registered 3x3 neighbourhood per real image pixel, with centre coordinates, to the downstream median/sort stage.
- Uses two line buffers and a 3x3 shift window. Left and top borders are forced to DUMMY. Right and bottom borders come from the dummy samples already present in the stream.

---
 rtl/window3x3_from_extended_pkg.sv | 50 +++++
 rtl/window3x3_from_extended_linebuf_2row.sv | 28 ++
 rtl/window3x3_from_extended.sv | 82 ++++++++
 tb/tb_window3x3_from_extended.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/window3x3_from_extended_pkg.sv
// rtl/window3x3_from_extended_pkg.sv - shared window constants and packing helpers
package window3x3_from_extended_pkg;

  localparam logic [7:0] DUMMY_DEFAULT = 8'h00;
  localparam int TAP_N = 9;
  localparam int TAP_C = 4;

  // Extended stream carries one trailing dummy column per line.
  function automatic int line_w(input int width);
    return width + 1;
  endfunction

  // Shift the 3x3 window left one column and load {top, mid, bot} as the right column.
  function automatic logic [8*TAP_N-1:0] shift_in(input logic [8*TAP_N-1:0] w,
                                                  input logic [7:0] top,
                                                  input logic [7:0] mid,
                                                  input logic [7:0] bot);
    logic [8*TAP_N-1:0] n;
    n = w;
    for (int r = 0; r < 3; r++) begin
      n[8*(3*r)+:8]   = w[8*(3*r+1)+:8];
      n[8*(3*r+1)+:8] = w[8*(3*r+2)+:8];
    end
    n[8*2+:8] = top;
    n[8*5+:8] = mid;
    n[8*8+:8] = bot;
    return n;
  endfunction

  // Top and left borders are synthesised here; right and bottom arrive in the stream.
  function automatic logic [8*TAP_N-1:0] mask_window(input logic [8*TAP_N-1:0] w,
                                                     input logic top_edge,
                                                     input logic left_edge,
                                                     input logic [7:0] dummy);
    logic [8*TAP_N-1:0] n;
    n = w;
    if (top_edge) begin
      n[8*0+:8] = dummy;
      n[8*1+:8] = dummy;
      n[8*2+:8] = dummy;
    end
    if (left_edge) begin
      n[8*0+:8] = dummy;
      n[8*3+:8] = dummy;
      n[8*6+:8] = dummy;
    end
    return n;
  endfunction

endpackage

// File: rtl/window3x3_from_extended_linebuf_2row.sv
// rtl/window3x3_from_extended_linebuf_2row.sv - two-line buffer, read-before-write at one column
module linebuf_2row #(
  parameter int LINE_W = 431,
  parameter int AW     = $clog2(LINE_W)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    top,
  output logic [7:0]    mid
);

  logic [7:0] lb_a [LINE_W];
  logic [7:0] lb_b [LINE_W];

  assign top = lb_b[addr];
  assign mid = lb_a[addr];

  // lb_a holds the previous line, lb_b the one before it; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      lb_b[addr] <= lb_a[addr];
      lb_a[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window3x3_from_extended.sv
// rtl/window3x3_from_extended.sv - 3x3 neighbourhood generator over the extended raster stream
module window3x3_from_extended
  import window3x3_from_extended_pkg::*;
#(
  parameter int         WIDTH   = 430,
  parameter int         HEIGHT  = 554,
  parameter logic [7:0] DUMMY   = DUMMY_DEFAULT,
  parameter int         COORD_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_pixel,
  input  logic               in_done,
  output logic               out_valid,
  output logic [71:0]        out_window,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_done,
  output logic               frame_err
);

  localparam int                 LINE_W   = line_w(WIDTH);
  localparam int                 AW       = $clog2(LINE_W);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(LINE_W - 1);
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(HEIGHT);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

  logic [COORD_W-1:0] col, row;
  logic [71:0]        win, win_next;
  logic [7:0]         top, mid;
  logic               at_last, interior;

  linebuf_2row #(.LINE_W(LINE_W), .AW(AW)) u_linebuf (
    .clk  (clk),
    .we   (in_valid & ~rst),
    .addr (col[AW-1:0]),
    .wdata(in_pixel),
    .top  (top),
    .mid  (mid)
  );

  assign win_next = shift_in(win, top, mid, in_pixel);
  assign at_last  = (col == LAST_COL) && (row == LAST_ROW);
  // Column 0 and line 0 of the stream only prime the window; the centre lags by one in x and y.
  assign interior = (col != '0) && (row != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      win        <= {TAP_N{DUMMY}};
      out_valid  <= 1'b0;
      out_window <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_done   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_done  <= 1'b0;
      if (in_done && !(in_valid && at_last)) frame_err <= 1'b1;
      if (in_valid) begin
        win      <= win_next;
        out_done <= at_last;
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + ONE;
        end else begin
          col <= col + ONE;
        end
        if (interior) begin
          out_valid  <= 1'b1;
          out_x      <= col - ONE;
          out_y      <= row - ONE;
          out_window <= mask_window(win_next, row == ONE, col == ONE, DUMMY);
        end
      end
    end
  end

endmodule

// File: tb/tb_window3x3_from_extended.sv
// tb/tb_window3x3_from_extended.sv - directed bench for the 3x3 window generator
module tb_window3x3_from_extended;

  localparam int W = 4;
  localparam int H = 3;
  localparam logic [7:0] D = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv = 1'b0, id = 1'b0, iv2 = 1'b0, id2 = 1'b0;
  logic [7:0] ip = '0, ip2 = '0;
  logic ov, od, fe, ov2, od2, fe2;
  logic [71:0] ow, ow2;
  logic [15:0] ox, oy, ox2, oy2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  int last_acc2 = 0;

  logic [71:0] wq[$], wq2[$];
  int xq[$], yq[$], xq2[$], yq2[$];
  int dq[$], dq2[$];

  window3x3_from_extended #(.WIDTH(W), .HEIGHT(H), .DUMMY(D), .COORD_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_pixel(ip), .in_done(id),
    .out_valid(ov), .out_window(ow), .out_x(ox), .out_y(oy), .out_done(od), .frame_err(fe)
  );

  window3x3_from_extended #(.WIDTH(1), .HEIGHT(1), .DUMMY(D), .COORD_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_pixel(ip2), .in_done(id2),
    .out_valid(ov2), .out_window(ow2), .out_x(ox2), .out_y(oy2), .out_done(od2), .frame_err(fe2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov) begin wq.push_back(ow); xq.push_back(int'(ox)); yq.push_back(int'(oy)); end
    if (od) dq.push_back(cyc);
    if (ov2) begin wq2.push_back(ow2); xq2.push_back(int'(ox2)); yq2.push_back(int'(oy2)); end
    if (od2) dq2.push_back(cyc);
  end

  function automatic logic [71:0] p9(input logic [7:0] t0, t1, t2, t3, t4, t5, t6, t7, t8);
    return {t8, t7, t6, t5, t4, t3, t2, t1, t0};
  endfunction

  // Geometric reference: neighbour outside the real image reads as D.
  function automatic logic [71:0] exp_win(input int x, input int y, input int off);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) begin
      int px, py;
      px = x + (i % 3) - 1;
      py = y + (i / 3) - 1;
      if (px < 0 || py < 0 || px >= W || py >= H) r[8*i+:8] = D;
      else r[8*i+:8] = 8'(16 * py + px + 1 + off);
    end
    return r;
  endfunction

  task automatic clear_q();
    wq.delete(); xq.delete(); yq.delete(); dq.delete();
    wq2.delete(); xq2.delete(); yq2.delete(); dq2.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    iv = 1'b0; id = 1'b0; iv2 = 1'b0; id2 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] px, input logic d);
    iv = 1'b1; ip = px; id = d;
    @(posedge clk); #1;
    last_acc = cyc;
    iv = 1'b0; id = 1'b0;
  endtask

  task automatic send2(input logic [7:0] px, input logic d);
    iv2 = 1'b1; ip2 = px; id2 = d;
    @(posedge clk); #1;
    last_acc2 = cyc;
    iv2 = 1'b0; id2 = 1'b0;
  endtask

  // Emulates the extender: (W+1) x (H+1) samples, dummy column and line at the end.
  task automatic send_frame(input int off, input int gap, input int first, input int count);
    int k;
    k = 0;
    for (int r = 0; r <= H; r++) begin
      for (int c = 0; c <= W; c++) begin
        if (k >= first && k < first + count) begin
          send((r < H && c < W) ? 8'(16 * r + c + 1 + off) : D, (r == H && c == W));
          idle(gap);
        end
        k++;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int base, input int off);
    for (int i = 0; i < W * H; i++) begin
      checks++;
      if (base + i >= wq.size()) begin
        errors++;
        $display("FAIL %s window %0d missing: got %0d windows", tag, i, wq.size());
      end else if (wq[base+i] !== exp_win(i % W, i / W, off) || xq[base+i] !== i % W || yq[base+i] !== i / W) begin
        errors++;
        $display("FAIL %s window %0d: got %h at (%0d,%0d), expected %h at (%0d,%0d)", tag, i,
                 wq[base+i], xq[base+i], yq[base+i], exp_win(i % W, i / W, off), i % W, i / W);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ov, od, fe, ox, oy, ow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%b e=%b x=%0d y=%0d w=%h, expected all zero", ov, od, fe, ox, oy, ow);
    end
    checks++;
    if ({ov2, od2, fe2} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs_small: got %b, expected 000", {ov2, od2, fe2});
    end
  endtask

  task automatic test_continuous();
    clear_q();
    send_frame(0, 0, 0, 20);
    idle(3);
    checks++;
    if (wq.size() != 12) begin errors++; $display("FAIL cont_count: got %0d, expected 12", wq.size()); end
    checks++;
    if (wq.size() < 1 || wq[0] !== p9(D, D, D, D, 1, 2, D, 17, 18)) begin
      errors++; $display("FAIL cont_win_0_0: got %h", wq.size() > 0 ? wq[0] : 72'hx);
    end
    checks++;
    if (wq.size() < 4 || wq[3] !== p9(D, D, D, 3, 4, D, 19, 20, D)) begin
      errors++; $display("FAIL cont_win_3_0: got %h", wq.size() > 3 ? wq[3] : 72'hx);
    end
    checks++;
    if (wq.size() < 10 || wq[9] !== p9(17, 18, 19, 33, 34, 35, D, D, D)) begin
      errors++; $display("FAIL cont_win_1_2: got %h", wq.size() > 9 ? wq[9] : 72'hx);
    end
    check_frame("cont", 0, 0);
    checks++;
    if (dq.size() != 1 || dq[0] != last_acc) begin
      errors++; $display("FAIL cont_done: got %0d pulses first at %0d, expected 1 at %0d", dq.size(), dq.size() > 0 ? dq[0] : -1, last_acc);
    end
    checks++;
    if (fe !== 1'b0) begin errors++; $display("FAIL cont_frame_err: got %b, expected 0", fe); end
  endtask

  task automatic test_gaps();
    clear_q();
    send_frame(0, 1, 0, 20);
    idle(3);
    checks++;
    if (wq.size() != 12) begin errors++; $display("FAIL gap_count: got %0d, expected 12", wq.size()); end
    check_frame("gap", 0, 0);
    checks++;
    if (dq.size() != 1 || dq[0] != last_acc) begin
      errors++; $display("FAIL gap_done: got %0d pulses first at %0d, expected 1 at %0d", dq.size(), dq.size() > 0 ? dq[0] : -1, last_acc);
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    send_frame(0, 0, 0, 20);
    send_frame(100, 0, 0, 20);
    idle(3);
    checks++;
    if (wq.size() != 24) begin errors++; $display("FAIL b2b_count: got %0d, expected 24", wq.size()); end
    checks++;
    if (wq.size() < 13 || wq[12] !== p9(D, D, D, D, 101, 102, D, 117, 118)) begin
      errors++; $display("FAIL b2b_win2_0_0: got %h", wq.size() > 12 ? wq[12] : 72'hx);
    end
    check_frame("b2b_f1", 0, 0);
    check_frame("b2b_f2", 12, 100);
    checks++;
    if (dq.size() != 2) begin errors++; $display("FAIL b2b_done: got %0d pulses, expected 2", dq.size()); end
  endtask

  task automatic test_reset_mid();
    clear_q();
    send_frame(50, 0, 0, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, expected 0", ov); end
    clear_q();
    send_frame(0, 0, 0, 20);
    idle(3);
    checks++;
    if (wq.size() != 12) begin errors++; $display("FAIL midrst_count: got %0d, expected 12", wq.size()); end
    check_frame("midrst", 0, 0);
  endtask

  task automatic test_frame_err();
    do_reset();
    send_frame(0, 0, 0, 9);
    checks++;
    if (fe !== 1'b0) begin errors++; $display("FAIL ferr_before: got %b, expected 0", fe); end
    send(8'd19, 1'b1);
    checks++;
    if (fe !== 1'b1) begin errors++; $display("FAIL ferr_rise: got %b, expected 1", fe); end
    send_frame(0, 0, 10, 10);
    idle(2);
    checks++;
    if (fe !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b, expected 1", fe); end
    do_reset();
    checks++;
    if (fe !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b, expected 0", fe); end
  endtask

  task automatic test_single_pixel();
    clear_q();
    send2(8'h55, 1'b0);
    send2(D, 1'b0);
    send2(D, 1'b0);
    send2(D, 1'b1);
    idle(3);
    checks++;
    if (wq2.size() != 1 || wq2[0] !== p9(D, D, D, D, 8'h55, D, D, D, D) || xq2[0] != 0 || yq2[0] != 0) begin
      errors++; $display("FAIL single_win: got %0d windows first %h", wq2.size(), wq2.size() > 0 ? wq2[0] : 72'hx);
    end
    checks++;
    if (dq2.size() != 1 || dq2[0] != last_acc2 || fe2 !== 1'b0) begin
      errors++; $display("FAIL single_done: got %0d pulses err=%b, expected 1 at %0d err=0", dq2.size(), fe2, last_acc2);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    test_frame_err();
    test_single_pixel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
